// File: rtl/scan_dff.sv
// Mux-D scan register: parallel capture when SE=0, serial shift SI->Q[0]->..->SO when SE=1.
// Optional macro SCAN_DFF_LOCKUP_EN retimes SO through a falling-edge lock-up flop.
module scan_dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic se,
  input  logic d,
  input  logic si,
  input  logic rv,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= rv;
    else if (se) q <= si;
    else         q <= d;
  end
endmodule

module scan_dff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             SI,
  input  logic             SE,
  output logic [WIDTH-1:0] Q,
  output logic             SO
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic sin;
    // cell 0 takes the chain input, every other cell takes its predecessor
    if (i == 0) begin : g_head
      assign sin = SI;
    end else begin : g_tail
      assign sin = Q[i-1];
    end
    scan_dff_cell u_cell (
      .clk (CLK),
      .rst (RST),
      .se  (SE),
      .d   (DI[i]),
      .si  (sin),
      .rv  (RESET_VAL[i]),
      .q   (Q[i])
    );
  end

`ifdef SCAN_DFF_LOCKUP_EN
  // Half-cycle retiming for hold margin into a skewed downstream domain;
  // after a reset edge Q[WIDTH-1] already holds RESET_VAL[WIDTH-1].
  logic so_lk;
  always_ff @(negedge CLK) so_lk <= Q[WIDTH-1];
  assign SO = so_lk;
`else
  assign SO = Q[WIDTH-1];
`endif
endmodule

// File: tb/tb_scan_dff.sv
// Directed bench for scan_dff: WIDTH=1 and WIDTH=4 chains, plus a WIDTH=4 instance
// with a non-zero reset value.
module tb_scan_dff;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, se1, si1;
  logic [0:0] di1, q1;
  logic       so1;
  logic       rst4, se4, si4;
  logic [3:0] di4, q4, q4r;
  logic       so4, so4r;

  scan_dff #(.WIDTH(1)) u1 (
    .CLK(clk), .RST(rst1), .DI(di1), .SI(si1), .SE(se1), .Q(q1), .SO(so1));
  scan_dff #(.WIDTH(4)) u4 (
    .CLK(clk), .RST(rst4), .DI(di4), .SI(si4), .SE(se4), .Q(q4), .SO(so4));
  scan_dff #(.WIDTH(4), .RESET_VAL(4'b1001)) u4r (
    .CLK(clk), .RST(rst4), .DI(di4), .SI(si4), .SE(se4), .Q(q4r), .SO(so4r));

  int checks = 0;
  int errors = 0;

`ifdef SCAN_DFF_LOCKUP_EN
  localparam bit LOCKUP = 1'b1;
`else
  localparam bit LOCKUP = 1'b0;
`endif

  typedef struct {
    logic       dut;  // 0: u1, 1: u4
    logic       rst;
    logic       se;
    logic [3:0] di;
    logic       si;
    logic [3:0] q;    // expected Q after the edge
  } vec_t;

  vec_t tv [29];

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic idle_all();
    rst1 = 1'b0; se1 = 1'b0; di1 = 1'b0; si1 = 1'b0;
    rst4 = 1'b0; se4 = 1'b0; di4 = 4'h0; si4 = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    logic [3:0] aq;
    logic       so_exp;
    idle_all();
    if (v.dut == 1'b0) begin
      rst1 = v.rst; se1 = v.se; di1 = v.di[0]; si1 = v.si;
    end else begin
      rst4 = v.rst; se4 = v.se; di4 = v.di; si4 = v.si;
    end
    so_exp = v.dut ? v.q[3] : v.q[0];
    @(posedge clk); #1;
    aq = v.dut ? q4 : {3'b000, q1};
    chk("q", idx, aq, v.q);
    if (!LOCKUP) chk("so_comb", idx, {3'b000, v.dut ? so4 : so1}, {3'b000, so_exp});
    if (v.dut && v.rst) chk("q_rstval", idx, q4r, 4'b1001);
    @(negedge clk); #1;
    chk("so", idx, {3'b000, v.dut ? so4 : so1}, {3'b000, so_exp});
  endtask

  initial begin
    idle_all();
    // WIDTH=1: reset, capture, X immunity, shift, reset during shift
    tv[0]  = '{1'b0, 1'b1, 1'b0, 4'h1,    1'b0, 4'h0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 4'h0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 4'h0};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 4'h0,    1'bx, 4'h0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 4'h1,    1'b0, 4'h1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 4'h1,    1'b1, 4'h1};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 4'h0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 4'h1,    1'b1, 4'h1};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 4'h1,    1'b1, 4'h1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 4'bxxxx, 1'b1, 4'h1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 4'h1,    1'b0, 4'h0};
    tv[11] = '{1'b0, 1'b1, 1'b1, 4'h1,    1'b1, 4'h0};
    // WIDTH=4: reset, shift 1,0,1,1 then flush with zeros
    tv[12] = '{1'b1, 1'b1, 1'b0, 4'hf,    1'b0, 4'h0};
    tv[13] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b1, 4'b0001};
    tv[14] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 4'b0010};
    tv[15] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b1, 4'b0101};
    tv[16] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b1, 4'b1011};
    tv[17] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 4'b0110};
    tv[18] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 4'b1100};
    tv[19] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 4'b1000};
    tv[20] = '{1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 4'b0000};
    // shift in 1010, capture 0110, then reset overrides a shift
    tv[21] = '{1'b1, 1'b0, 1'b1, 4'hf,    1'b1, 4'b0001};
    tv[22] = '{1'b1, 1'b0, 1'b1, 4'hf,    1'b0, 4'b0010};
    tv[23] = '{1'b1, 1'b0, 1'b1, 4'hf,    1'b1, 4'b0101};
    tv[24] = '{1'b1, 1'b0, 1'b1, 4'hf,    1'b0, 4'b1010};
    tv[25] = '{1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 4'b0110};
    tv[26] = '{1'b1, 1'b1, 1'b1, 4'hf,    1'b1, 4'b0000};
    tv[27] = '{1'b1, 1'b0, 1'b0, 4'b1001, 1'bx, 4'b1001};
    tv[28] = '{1'b1, 1'b0, 1'b1, 4'bxxxx, 1'b0, 4'b0010};

    @(negedge clk); #1;
    for (int i = 0; i < 29; i++) run_row(i, tv[i]);

    // reset is sampled only at the edge: raising it mid-cycle changes nothing yet
    idle_all();
    se4 = 1'b1; rst4 = 1'b1; si4 = 1'b1;
    #1;
    chk("rst_sync_q", 100, q4, 4'b0010);
    chk("rst_sync_so", 100, {3'b000, so4}, 4'b0000);
    @(posedge clk); #1;
    chk("rst_edge_q", 101, q4, 4'b0000);
    chk("rst_edge_qr", 101, q4r, 4'b1001);
    @(negedge clk); #1;
    chk("rst_edge_so_r", 101, {3'b000, so4r}, 4'b0001);

    // u1 idled at 0; shift a 1 and watch when SO follows Q
    idle_all();
    @(posedge clk); #1;
    chk("lk_pre_q", 102, {3'b000, q1}, 4'b0000);
    @(negedge clk); #1;
    se1 = 1'b1; si1 = 1'b1;
    @(posedge clk); #1;
    chk("lk_q_rise", 103, {3'b000, q1}, 4'b0001);
    chk("lk_so_after_pos", 103, {3'b000, so1}, LOCKUP ? 4'b0000 : 4'b0001);
    #3;
    chk("lk_so_before_neg", 104, {3'b000, so1}, LOCKUP ? 4'b0000 : 4'b0001);
    @(negedge clk); #1;
    chk("lk_so_after_neg", 105, {3'b000, so1}, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
